// File: rtl/dpram64_writer.sv
// rtl/dpram64_writer.sv - byte stream to 64-bit dual-port RAM writer with lane packing
// Packs accepted bytes into 8-byte words and issues one registered write per word.
module dpram64_writer #(
    parameter int SIZE = 4096,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          abort,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [7:0]    we,
    output logic [63:0]   din,
    output logic [AW-1:0] waddr,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cur_addr_q;
    logic [AW:0]   remaining_q;
    logic [63:0]   pack_q;
    logic [7:0]    mask_q;
    logic [7:0]    we_q;
    logic [63:0]   din_q;
    logic [AW-1:0] waddr_q;
    logic          done_q;
    logic          run_c;

    logic [2:0]    lane;
    logic [7:0]    lane_bit;
    logic [63:0]   merged;
    logic          accept;
    logic          last;
    logic          flush;

    assign lane     = cur_addr_q[2:0];
    assign lane_bit = 8'd1 << lane;
    assign merged   = pack_q | ({56'd0, i_data} << {lane, 3'b000});
    // A byte offered alongside abort is refused so the partial word dies cleanly.
    assign accept   = i_valid && run_c && !abort;
    assign last     = (remaining_q == {{AW{1'b0}}, 1'b1});
    assign flush    = (lane == 3'd7) || last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && (len != '0)) state_d = RUN;
            RUN: begin
                if (abort)              state_d = IDLE;
                else if (accept && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run_c   = (state_q == RUN);
        busy    = run_c;
        o_ready = run_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr_q  <= '0;
            remaining_q <= '0;
            pack_q      <= '0;
            mask_q      <= '0;
            we_q        <= '0;
            din_q       <= '0;
            waddr_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            we_q   <= '0;
            din_q  <= '0;
            done_q <= 1'b0;
            if (!run_c && start) begin
                cur_addr_q  <= base_addr;
                remaining_q <= len;
                pack_q      <= '0;
                mask_q      <= '0;
                if (len == '0) done_q <= 1'b1;
            end else if (run_c && abort) begin
                pack_q <= '0;
                mask_q <= '0;
            end else if (accept) begin
                cur_addr_q  <= cur_addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                if (flush) begin
                    we_q    <= mask_q | lane_bit;
                    din_q   <= merged;
                    waddr_q <= {cur_addr_q[AW-1:3], 3'b000};
                    done_q  <= last;
                    pack_q  <= '0;
                    mask_q  <= '0;
                end else begin
                    pack_q <= merged;
                    mask_q <= mask_q | lane_bit;
                end
            end
        end
    end

    assign we    = we_q;
    assign din   = din_q;
    assign waddr = waddr_q;
    assign done  = done_q;

endmodule

// File: tb/tb_dpram64_writer.sv
// tb/tb_dpram64_writer.sv - scoreboard bench for dpram64_writer
module tb_dpram64_writer;

    localparam int SIZE = 4096;
    localparam int AW   = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          abort;
    logic [7:0]    i_data;
    logic          i_valid;
    logic          o_ready;
    logic [7:0]    we;
    logic [63:0]   din;
    logic [AW-1:0] waddr;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [7:0]    we;
        logic [63:0]   din;
        logic          done;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    dpram64_writer #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .abort(abort), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .we(we), .din(din), .waddr(waddr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] w,
                             input logic [63:0] d, input logic dn);
        wr_t e;
        e.waddr = a; e.we = w; e.din = d; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1; base_addr = b; len = l;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        i_valid = 1'b1; i_data = b;
        step();
        i_valid = 1'b0;
    endtask

    // Monitor: every cycle with a write or done must match the head of the scoreboard.
    always @(negedge clk) begin
        if (we != 8'd0 || done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual we=%h done=%b waddr=%h din=%h required none",
                         we, done, waddr, din);
            end else begin
                wr_t e;
                wr_t a;
                e = exp_q.pop_front();
                a.waddr = (e.we != 8'd0) ? waddr : e.waddr;
                a.we = we; a.din = din; a.done = done;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL write actual waddr=%h we=%h din=%h done=%b required waddr=%h we=%h din=%h done=%b",
                             a.waddr, a.we, a.din, a.done, e.waddr, e.we, e.din, e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        abort = 1'b0; i_data = '0; i_valid = 1'b0;
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ready", {63'd0, o_ready}, 64'd0);
        check("reset_we", {56'd0, we}, 64'd0);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Aligned burst
        expect_wr(12'h000, 8'hFF, 64'h0706050403020100, 1'b0);
        expect_wr(12'h008, 8'hFF, 64'h0F0E0D0C0B0A0908, 1'b1);
        do_start(12'h000, 13'd16);
        check("run_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 16; i++) send(8'(i));
        repeat (3) step();

        // Unaligned start
        expect_wr(12'h008, 8'hE0, 64'hA3A2A10000000000, 1'b0);
        expect_wr(12'h010, 8'h03, 64'h000000000000A5A4, 1'b1);
        do_start(12'h00D, 13'd5);
        for (int i = 1; i <= 5; i++) send(8'hA0 + 8'(i));
        repeat (3) step();

        // Reset mid-transfer, then a fresh transfer
        do_start(12'h020, 13'd8);
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
        rst = 1'b1;
        #2;
        check("rst_waddr", {52'd0, waddr}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_din", din, 64'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        expect_wr(12'h040, 8'hFF, 64'hC7C6C5C4C3C2C1C0, 1'b1);
        do_start(12'h040, 13'd8);
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i));
        repeat (3) step();

        // Backpressure gaps
        expect_wr(12'h000, 8'hFF, 64'h1716151413121110, 1'b1);
        do_start(12'h000, 13'd8);
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i));
            step();
        end
        repeat (3) step();

        // Wrap across the top of the RAM
        expect_wr(12'hFF8, 8'hC0, 64'hB2B1000000000000, 1'b0);
        expect_wr(12'h000, 8'h03, 64'h000000000000B4B3, 1'b1);
        do_start(12'hFFE, 13'd4);
        for (int i = 1; i <= 4; i++) send(8'hB0 + 8'(i));
        repeat (3) step();

        // Abort after three bytes; the byte offered with abort is refused
        do_start(12'h100, 13'd8);
        for (int i = 0; i < 3; i++) send(8'h70 + 8'(i));
        abort = 1'b1; i_valid = 1'b1; i_data = 8'h73;
        step();
        abort = 1'b0; i_valid = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_ready", {63'd0, o_ready}, 64'd0);
        repeat (4) step();

        // Zero-length start
        expect_wr(12'h000, 8'h00, 64'h0, 1'b1);
        do_start(12'h200, 13'd0);
        check("len0_busy", {63'd0, busy}, 64'd0);
        repeat (4) step();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram64_writer.md
DPRAM64_WRITER -- requirements
Module: dpram64_writer

Interface
REQ-001 SHALL have parameter SIZE, default 4096, meaning target RAM size in bytes; power of two, >= 16; AW = log2(SIZE).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a transfer; honoured only in IDLE.
REQ-005 SHALL have port base_addr  input  AW  byte address of the first byte; sampled on an accepted start.
REQ-006 SHALL have port len  input  AW+1  transfer length in bytes (0..SIZE); sampled on an accepted start.
REQ-007 SHALL have port abort  input  1  terminates an active transfer.
REQ-008 SHALL have port i_data  input  8  stream byte.
REQ-009 SHALL have port i_valid  input  1  i_data is valid.
REQ-010 SHALL have port o_ready  output  1  the writer accepts i_data this cycle.
REQ-011 SHALL have port we  output  8  RAM byte-lane write enables.
REQ-012 SHALL have port din  output  64  RAM write data; byte k is on din[8k+7:8k].
REQ-013 SHALL have port waddr  output  AW  RAM byte address; bits [2:0] always 0.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE and RUN.
- IDLE -> RUN on start with len != 0.
- RUN -> IDLE when the last byte is accepted, or on abort.
REQ-017 SHALL treat start with len == 0 in IDLE as a transfer with no writes: stay in IDLE and pulse done on the next cycle.
REQ-018 SHALL ignore start while in RUN; base_addr and len are not resampled.
REQ-019 SHALL drive o_ready = busy, combinationally.
- A byte is accepted when i_valid && o_ready.
- The block has no internal stall, so a byte can be accepted on every RUN cycle.
REQ-020 SHALL place each byte in lane = cur_addr[2:0].
- cur_addr starts at base_addr.
- cur_addr increments by 1 per accepted byte and wraps modulo SIZE.
REQ-021 SHALL hold a 64-bit pack buffer and an 8-bit lane mask that accumulate accepted bytes.
REQ-022 SHALL flush when an accepted byte lands in lane 7 or is the last byte of the transfer. The flush cycle:
- loads registered we with the mask OR (1 << lane);
- loads din with the buffer merged with the new byte;
- loads waddr with {cur_addr[AW-1:3], 3'b000};
- clears the mask.
The outputs are visible in the following cycle.
REQ-023 SHALL drive we = 0 on every cycle that does not follow a flush; each write pulse lasts exactly one cycle.
REQ-024 SHALL drive din lanes whose we bit is 0 to 0.
REQ-025 SHALL pulse done in the same cycle as the final write's we.
REQ-026 SHALL handle abort in RUN as follows:
- return to IDLE on the next edge;
- discard the partial buffer with no write;
- do not assert done;
- a byte offered in the same cycle as abort is not accepted, and o_ready goes low next cycle;
- a flush registered in the prior cycle still completes.
REQ-027 SHALL make an unaligned start with a short length produce a single partial write, e.g. base_addr[2:0] = 5 with len = 2 gives we = 8'b0110_0000.
REQ-028 SHALL wrap a transfer that crosses address SIZE-1 to word 0; the mask is flushed at lane 7 before the wrap.

Reset
REQ-029 SHALL, while rst is high, asynchronously force:
- state to IDLE;
- we, din, waddr, busy, done and o_ready to 0;
- the pack buffer, mask and counters to 0.
REQ-030 SHALL discard an in-flight transfer on reset without generating any write; operation resumes only on a new start after rst is deasserted.

Verification
REQ-031 SHALL be checked for aligned burst: base 0x000, len 16, bytes 0x00..0x0F on consecutive cycles -> two writes:
- waddr 0x000, we 0xFF, din 0x0706050403020100;
- then waddr 0x008, we 0xFF, din 0x0F0E0D0C0B0A0908, with done in the same cycle.
REQ-032 SHALL be checked for unaligned: base 0x00D, len 5, bytes A1..A5 -> two writes:
- waddr 0x008, we 0xE0, din 0xA3A2A10000000000;
- then waddr 0x010, we 0x03, din 0x000000000000A5A4, with done.
REQ-033 SHALL be checked for backpressure gaps: len 8 at base 0, i_valid toggling every other cycle -> exactly one write (we 0xFF) after the 8th accepted byte, and no other cycle with we != 0.
REQ-034 SHALL be checked for wrap: SIZE 4096, base 0xFFE, len 4 -> two writes:
- waddr 0xFF8, we 0xC0;
- then waddr 0x000, we 0x03, with done.
REQ-035 SHALL be checked for abort and len 0:
- abort after 3 bytes -> no write, no done, busy low next cycle;
- start with len 0 -> done next cycle, we stays 0.
REQ-036 SHALL be checked for reset mid-transfer: rst asserted after 5 of 8 bytes -> all outputs 0 immediately, no write, and a fresh transfer after reset completes correctly.
